ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//   Shares one single-port synchronous CPU RAM (1-cycle read latency) between the stack
//   machine (priority port) and a read-only sprite/video fetch port. Adds a stall output
//   to the CPU so the video port is never starved. Sits between the core and the RAM macro.
// PARAMETERS
//   DATA_W     16  RAM word width (matches `CPU_WIDTH)
//   ADDR_W      9  RAM word address width (512 words)
//   STARVE_MAX  4  consecutive denied video cycles before a forced video grant (>=1)
// PORTS
//   clock       in   1       system clock, all state on rising edge
//   reset_n     in   1       asynchronous, active-low reset
//   cpu_req     in   1       CPU access request this cycle
//   cpu_we      in   1       CPU write (1) / read (0)
//   cpu_addr    in   ADDR_W  CPU word address
//   cpu_wdata   in   DATA_W  CPU write data
//   cpu_stall   out  1       CPU access NOT accepted this cycle; CPU must hold and retry
//   cpu_rdata   out  DATA_W  CPU read data
//   cpu_rvalid  out  1       cpu_rdata valid (1 cycle after accepted CPU read)
//   vid_req     in   1       video read request; held with vid_addr until vid_gnt
//   vid_addr    in   ADDR_W  video word address
//   vid_gnt     out  1       video request accepted this cycle
//   vid_rdata   out  DATA_W  video read data
//   vid_rvalid  out  1       vid_rdata valid (1 cycle after vid_gnt)
//   ram_addr    out  ADDR_W  to RAM
//   ram_we      out  1       to RAM
//   ram_wdata   out  DATA_W  to RAM
//   ram_rdata   in   DATA_W  from RAM, registered by RAM (valid cycle after address)
// BEHAVIOUR
//   - Grant decision is combinational per cycle: force = vid_req && (starve_cnt == STARVE_MAX).
//     force           -> video owns RAM; cpu_stall = cpu_req; vid_gnt = 1.
//     else cpu_req    -> CPU owns RAM; cpu_stall = 0; vid_gnt = 0.
//     else vid_req    -> video owns RAM; vid_gnt = 1.
//     else            -> idle; ram_we = 0, ram_addr = cpu_addr.
//   - ram_we = 1 only when CPU owns and cpu_we; video never writes. ram_wdata = cpu_wdata always.
//   - starve_cnt (clog2(STARVE_MAX+1) bits): increments when vid_req && !vid_gnt,
//     saturates at STARVE_MAX; clears on vid_gnt or !vid_req.
//   - Return tag register ret_q in {NONE, CPU, VID}: set to CPU on accepted CPU read, VID on
//     vid_gnt, NONE otherwise (incl. CPU write). Next cycle: cpu_rvalid = (ret_q==CPU),
//     vid_rvalid = (ret_q==VID); both rdata outputs wired to ram_rdata (qualify by rvalid).
//   - Back-to-back: a new access may issue every cycle; reads fully pipelined, no bubbles.
//   - Stall: the CPU access stalled by force is not performed (no write, no rvalid); the
//     forced cycle is exactly one cycle, then counter clears and CPU resumes priority.
//   - Reset (async assert, sync-released by the clock domain): starve_cnt = 0, ret_q = NONE;
//     outputs cpu_rvalid = vid_rvalid = 0. Combinational outputs follow inputs with cnt = 0
//     (cpu_stall = 0 unless forced, which cannot occur in the reset state).
//     Reset mid-read: the pending return is discarded, no rvalid after release.
//   - No internal buffering; at most one access outstanding per port at any time.
// TESTING
//   1. CPU only: write 0x1234 @0x010, read @0x010 -> ram_we 1 cycle, cpu_rvalid next cycle
//      after read with cpu_rdata=0x1234, cpu_stall never asserted.
//   2. Video only: vid_req @0x020 (holds 0xBEEF) -> vid_gnt same cycle, vid_rvalid+0xBEEF next.
//   3. Starvation: cpu_req held high 10 cycles, vid_req high from cycle 0, STARVE_MAX=4 ->
//      vid_gnt and cpu_stall exactly in cycle 4 and cycle 9; all other cycles CPU served.
//   4. Simultaneous first request: cpu_req & vid_req together, cnt=0 -> CPU served, vid_gnt=0,
//      starve_cnt=1 next cycle; stalled CPU write in forced cycle leaves RAM unchanged.
//   5. Interleaved reads every cycle alternating owners -> each rvalid on correct port,
//      correct data, no lost or duplicated returns.
//   6. reset_n pulsed low between a CPU read grant and its return -> no cpu_rvalid,
//      starve_cnt=0, normal operation resumes on next request.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Signal bundle between the CPU, the video fetch port, the RAM macro and the arbiter.
// The arbiter uses the slave view; the environment driving it uses the master view.
interface ram_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_rvalid;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  vid_req, vid_addr,
    output vid_gnt, vid_rdata, vid_rvalid,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output vid_req, vid_addr,
    input  vid_gnt, vid_rdata, vid_rvalid,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: the CPU has priority, but a video request denied STARVE_MAX
// cycles in a row is forced through for one cycle while the CPU is stalled.
module ram_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  ram_port_arbiter_if.slave   arb_io
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    RET_NONE = 2'd0,
    RET_CPU  = 2'd1,
    RET_VID  = 2'd2
  } ret_e;

  ret_e             ret_q;
  ret_e             ret_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             force_s;
  logic             cpu_own_s;
  logic             vid_own_s;

  // Per-cycle ownership of the RAM port
  always_comb begin
    force_s   = 1'b0;
    cpu_own_s = 1'b0;
    vid_own_s = 1'b0;
    force_s   = arb_io.vid_req && (cnt_q == CNT_MAX);
    if (force_s) begin
      vid_own_s = 1'b1;
    end else if (arb_io.cpu_req) begin
      cpu_own_s = 1'b1;
    end else if (arb_io.vid_req) begin
      vid_own_s = 1'b1;
    end else begin
      cpu_own_s = 1'b0;
      vid_own_s = 1'b0;
    end
  end

  // Starvation counter and return-tag next state
  always_comb begin
    cnt_d = cnt_q;
    ret_d = RET_NONE;
    if (!arb_io.vid_req || vid_own_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
    // A CPU write produces no return, so the tag stays NONE for it
    if (cpu_own_s && !arb_io.cpu_we) begin
      ret_d = RET_CPU;
    end else if (vid_own_s) begin
      ret_d = RET_VID;
    end else begin
      ret_d = RET_NONE;
    end
  end

  // State registers; reset drops any return still in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {CNT_W{1'b0}};
      ret_q <= RET_NONE;
    end else begin
      cnt_q <= cnt_d;
      ret_q <= ret_d;
    end
  end

  assign arb_io.cpu_stall  = force_s && arb_io.cpu_req;
  assign arb_io.vid_gnt    = vid_own_s;
  assign arb_io.ram_we     = cpu_own_s && arb_io.cpu_we;
  assign arb_io.ram_addr   = vid_own_s ? arb_io.vid_addr : arb_io.cpu_addr;
  assign arb_io.ram_wdata  = arb_io.cpu_wdata;
  assign arb_io.cpu_rdata  = arb_io.ram_rdata;
  assign arb_io.vid_rdata  = arb_io.ram_rdata;
  assign arb_io.cpu_rvalid = (ret_q == RET_CPU);
  assign arb_io.vid_rvalid = (ret_q == RET_VID);

endmodule
